// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: pops bytes from the PS/2 receiver, decodes E0/F0 prefixes,
// tracks the currently held key, registers its ASCII and counts presses.
module ps2_key_ctrl #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_clrn,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_ready,
  input  logic             i_rx_overflow,
  output logic             o_nextdata_n,
  output logic [7:0]       o_scan_out,
  input  logic [7:0]       i_ascii_in,
  output logic             o_key_valid,
  output logic [7:0]       o_key_scan,
  output logic             o_key_ext,
  output logic [7:0]       o_key_ascii,
  output logic [CNT_W-1:0] o_press_cnt,
  output logic             o_err,
  input  logic             i_err_clr
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  state_t           r_state;
  logic [7:0]       r_byte;
  logic             r_nextdata_n;
  logic             r_ext_pend;
  logic             r_brk_pend;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_key_valid;
  logic [7:0]       r_key_scan;
  logic             r_key_ext;
  logic [7:0]       r_key_ascii;
  logic [CNT_W-1:0] r_press_cnt;
  logic             r_err;

  logic w_decode;
  logic w_pend;
  logic w_same_key;
  logic w_to_hit;

  assign w_decode   = (r_state == S_DECODE);
  assign w_pend     = r_ext_pend | r_brk_pend;
  // The captured code refers to the key already held (same code and same E0 flavour)
  assign w_same_key = r_key_valid && (r_byte == r_key_scan) && (r_ext_pend == r_key_ext);
  // A decode in the same cycle consumes the prefix, so it takes precedence over expiry
  assign w_to_hit   = w_pend && !w_decode && (r_to_cnt == TO_LAST);

  // Byte sequencer, prefix decoder, held-key tracker and prefix timeout
  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_state      <= S_IDLE;
      r_byte       <= 8'h00;
      r_nextdata_n <= 1'b1;
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
      r_to_cnt     <= '0;
      r_key_valid  <= 1'b0;
      r_key_scan   <= 8'h00;
      r_key_ext    <= 1'b0;
      r_press_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_nextdata_n <= 1'b1;
          if (i_rx_ready) begin
            r_byte       <= i_rx_data;
            r_nextdata_n <= 1'b0;
            r_state      <= S_POP;
          end
        end
        S_POP: begin
          r_nextdata_n <= 1'b1;
          r_state      <= S_DECODE;
        end
        S_DECODE: begin
          r_nextdata_n <= 1'b1;
          r_state      <= S_IDLE;
          if (r_byte == 8'hE0) begin
            r_ext_pend <= 1'b1;
          end else if (r_byte == 8'hF0) begin
            r_brk_pend <= 1'b1;
          end else begin
            if (r_brk_pend) begin
              if (w_same_key) begin
                r_key_valid <= 1'b0;
                r_key_scan  <= 8'h00;
              end
            end else if (!w_same_key) begin
              r_key_scan  <= r_byte;
              r_key_ext   <= r_ext_pend;
              r_key_valid <= 1'b1;
              r_press_cnt <= r_press_cnt + CNT_W'(1);
            end
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
          end
        end
        default: begin
          r_nextdata_n <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase

      if (w_decode) begin
        r_to_cnt <= '0;
      end else if (w_pend) begin
        if (w_to_hit) begin
          r_to_cnt   <= '0;
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  // Register the lookup result; extended keys have no ASCII mapping
  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_key_ascii <= 8'h00;
    end else begin
      r_key_ascii <= (r_key_valid && !r_key_ext) ? i_ascii_in : 8'h00;
    end
  end

  // Sticky error flag; a new error event beats a simultaneous clear
  always_ff @(posedge i_clk or negedge i_clrn) begin
    if (!i_clrn) begin
      r_err <= 1'b0;
    end else if (i_rx_overflow || w_to_hit) begin
      r_err <= 1'b1;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign o_nextdata_n = r_nextdata_n;
  assign o_scan_out   = r_key_valid ? r_key_scan : 8'h00;
  assign o_key_valid  = r_key_valid;
  assign o_key_scan   = r_key_scan;
  assign o_key_ext    = r_key_ext;
  assign o_key_ascii  = r_key_ascii;
  assign o_press_cnt  = r_press_cnt;
  assign o_err        = r_err;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Testbench for ps2_key_ctrl: scenario tasks plus randomized bytes checked
// against a keyboard-level model of held key, prefixes and press count.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_overflow = 1'b0;
  logic       err_clr = 1'b0;
  logic       nextdata_n;
  logic [7:0] scan_out;
  logic [7:0] ascii_in;
  logic       key_valid;
  logic [7:0] key_scan;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic [7:0] press_cnt;
  logic       err;

  ps2_key_ctrl #(.TIMEOUT_CYC(16), .CNT_W(8)) dut (
    .i_clk(clk), .i_clrn(clrn), .i_rx_data(rx_data), .i_rx_ready(rx_ready),
    .i_rx_overflow(rx_overflow), .o_nextdata_n(nextdata_n), .o_scan_out(scan_out),
    .i_ascii_in(ascii_in), .o_key_valid(key_valid), .o_key_scan(key_scan),
    .o_key_ext(key_ext), .o_key_ascii(key_ascii), .o_press_cnt(press_cnt),
    .o_err(err), .i_err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Scan-code lookup stand-in
  function automatic logic [7:0] lut(input logic [7:0] s);
    case (s)
      8'h1C:   lut = 8'h41;
      8'h16:   lut = 8'h31;
      8'h45:   lut = 8'h30;
      8'h32:   lut = 8'h42;
      8'h75:   lut = 8'h38;
      default: lut = 8'h3F;
    endcase
  endfunction
  assign ascii_in = lut(scan_out);

  int total = 0;
  int bad = 0;

  // Pop-strobe monitor
  int cyc = 0;
  int pulse_cyc[$];
  int dbl_low = 0;
  logic prev_low = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!nextdata_n) begin
      pulse_cyc.push_back(cyc);
      if (prev_low) dbl_low <= dbl_low + 1;
    end
    prev_low <= !nextdata_n;
  end

  // Keyboard-level reference model
  bit         m_valid, m_ext, m_ep, m_bp;
  logic [7:0] m_scan;
  logic [7:0] m_cnt;

  task automatic model_reset();
    m_valid = 0; m_ext = 0; m_ep = 0; m_bp = 0; m_scan = 8'h00; m_cnt = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bool_same: begin
      bit same;
      if (b == 8'hE0) m_ep = 1;
      else if (b == 8'hF0) m_bp = 1;
      else begin
        same = m_valid && (m_scan == b) && (m_ext == m_ep);
        if (m_bp) begin
          if (same) begin m_valid = 0; m_scan = 8'h00; end
        end else if (!same) begin
          m_scan = b; m_ext = m_ep; m_valid = 1; m_cnt = m_cnt + 8'd1;
        end
        m_ep = 0; m_bp = 0;
      end
    end
  endtask

  function automatic logic [7:0] m_ascii();
    m_ascii = (m_valid && !m_ext) ? lut(m_scan) : 8'h00;
  endfunction

  function automatic logic [31:0] keys_got();
    keys_got = {7'd0, key_valid, key_scan, 7'd0, key_ext, press_cnt};
  endfunction

  function automatic logic [31:0] keys_exp();
    keys_exp = {7'd0, m_valid, m_scan, 7'd0, m_ext, m_cnt};
  endfunction

  // Present one byte and let it run through capture, pop and decode (3 cycles).
  // rx_ready stays high so a following send() is back-to-back.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    model_byte(b);
  endtask

  task automatic idle(input int n);
    rx_ready = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    model_reset();
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (keys_got() !== keys_exp()) begin
      bad++; $display("FAIL reset_keys got=%h want=%h", keys_got(), keys_exp());
    end
    total++;
    if ({nextdata_n, err, key_ascii, scan_out} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
      bad++; $display("FAIL reset_misc got ndn=%b err=%b ascii=%h scan=%h want 1 0 00 00",
                      nextdata_n, err, key_ascii, scan_out);
    end
    clrn = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    send(8'h1C);
    total++;
    if (keys_got() !== keys_exp()) begin
      bad++; $display("FAIL basic_make got=%h want=%h", keys_got(), keys_exp());
    end
    idle(1);
    total++;
    if (key_ascii !== 8'h41) begin
      bad++; $display("FAIL basic_ascii got=%h want=41", key_ascii);
    end
    send(8'hF0);
    send(8'h1C);
    total++;
    if (keys_got() !== keys_exp()) begin
      bad++; $display("FAIL basic_release got=%h want=%h", keys_got(), keys_exp());
    end
    idle(1);
    total++;
    if (key_ascii !== m_ascii()) begin
      bad++; $display("FAIL basic_rel_ascii got=%h want=%h", key_ascii, m_ascii());
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [7:0] c0;
    n0 = pulse_cyc.size();
    c0 = press_cnt;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    idle(2);
    total++;
    if (pulse_cyc.size() - n0 != 5) begin
      bad++; $display("FAIL b2b_pulses got=%0d want=5", pulse_cyc.size() - n0);
    end
    for (int k = n0; k + 1 < pulse_cyc.size(); k++) begin
      total++;
      if (pulse_cyc[k+1] - pulse_cyc[k] != 3) begin
        bad++; $display("FAIL b2b_spacing got=%0d want=3", pulse_cyc[k+1] - pulse_cyc[k]);
      end
    end
    total++;
    if (press_cnt - c0 !== 8'd1) begin
      bad++; $display("FAIL b2b_presses got=%0d want=1", press_cnt - c0);
    end
    total++;
    if (keys_got() !== keys_exp()) begin
      bad++; $display("FAIL b2b_keys got=%h want=%h", keys_got(), keys_exp());
    end
  endtask

  task automatic test_extended();
    send(8'hE0); send(8'h75);
    total++;
    if (keys_got() !== keys_exp() || key_ext !== 1'b1) begin
      bad++; $display("FAIL ext_make got=%h want=%h", keys_got(), keys_exp());
    end
    idle(1);
    total++;
    if (key_ascii !== 8'h00) begin
      bad++; $display("FAIL ext_ascii got=%h want=00", key_ascii);
    end
    send(8'hF0); send(8'h75);
    total++;
    if (keys_got() !== keys_exp() || key_valid !== 1'b1) begin
      bad++; $display("FAIL ext_plain_rel got=%h want=%h", keys_got(), keys_exp());
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    total++;
    if (keys_got() !== keys_exp() || key_valid !== 1'b0) begin
      bad++; $display("FAIL ext_release got=%h want=%h", keys_got(), keys_exp());
    end
    idle(1);
  endtask

  task automatic test_timeout();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL to_clear got=%b want=0", err);
    end
    send(8'hF0);
    idle(15);
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL to_early got=%b want=0", err);
    end
    idle(1);
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL to_expire got=%b want=1", err);
    end
    m_bp = 0; m_ep = 0;
    send(8'h16);
    total++;
    if (keys_got() !== keys_exp() || key_valid !== 1'b1) begin
      bad++; $display("FAIL to_next_make got=%h want=%h", keys_got(), keys_exp());
    end
    idle(1);
    total++;
    if (key_ascii !== 8'h31) begin
      bad++; $display("FAIL to_ascii got=%h want=31", key_ascii);
    end
  endtask

  task automatic test_wrap();
    while (m_cnt != 8'hFF) begin
      send(8'h32); send(8'hF0); send(8'h32);
    end
    total++;
    if (press_cnt !== 8'hFF) begin
      bad++; $display("FAIL wrap_pre got=%h want=ff", press_cnt);
    end
    send(8'h32);
    total++;
    if (press_cnt !== 8'h00 || keys_got() !== keys_exp()) begin
      bad++; $display("FAIL wrap_zero got=%h want=%h", keys_got(), keys_exp());
    end
    idle(1);
  endtask

  task automatic test_overflow();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    rx_overflow = 1'b1;
    err_clr = 1'b1;
    idle(1);
    rx_overflow = 1'b0;
    err_clr = 1'b0;
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL ovf_set_wins got=%b want=1", err);
    end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got=%b want=0", err);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [7];
    int gap;
    pool = '{8'hE0, 8'hF0, 8'h1C, 8'h16, 8'h45, 8'h32, 8'h75};
    for (int i = 0; i < 60; i++) begin
      send(pool[$urandom_range(0, 6)]);
      total++;
      if (keys_got() !== keys_exp()) begin
        bad++; $display("FAIL rand_keys[%0d] got=%h want=%h", i, keys_got(), keys_exp());
      end
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        idle(gap);
        total++;
        if (key_ascii !== m_ascii()) begin
          bad++; $display("FAIL rand_ascii[%0d] got=%h want=%h", i, key_ascii, m_ascii());
        end
      end
    end
    idle(1);
  endtask

  task automatic test_midreset();
    rx_data = 8'h45;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    total++;
    if (nextdata_n !== 1'b0) begin
      bad++; $display("FAIL mid_pop got ndn=%b want=0", nextdata_n);
    end
    clrn = 1'b0;
    #1;
    model_reset();
    total++;
    if (keys_got() !== keys_exp() ||
        {nextdata_n, err, key_ascii} !== {1'b1, 1'b0, 8'h00}) begin
      bad++; $display("FAIL mid_reset got keys=%h ndn=%b err=%b ascii=%h want keys=%h 1 0 00",
                      keys_got(), nextdata_n, err, key_ascii, keys_exp());
    end
    idle(2);
    clrn = 1'b1;
    idle(1);
    total++;
    if (keys_got() !== keys_exp()) begin
      bad++; $display("FAIL mid_lost got=%h want=%h", keys_got(), keys_exp());
    end
    send(8'h45);
    total++;
    if (keys_got() !== keys_exp()) begin
      bad++; $display("FAIL mid_next got=%h want=%h", keys_got(), keys_exp());
    end
    idle(1);
    total++;
    if (key_ascii !== 8'h30) begin
      bad++; $display("FAIL mid_ascii got=%h want=30", key_ascii);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_extended();
    test_timeout();
    test_wrap();
    test_overflow();
    test_random();
    test_midreset();
    idle(2);
    total++;
    if (dbl_low != 0) begin
      bad++; $display("FAIL strobe_double got=%0d want=0", dbl_low);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_key_ctrl.md
# ps2_key_ctrl

Sequencing controller between the PS/2 byte receiver and the scan-code-to-ASCII lookup. It pops bytes from the receiver, decodes make/break/extended prefixes, and tracks the currently held key. It also drives the lookup with the held scan code, registers the returned ASCII, and counts distinct key presses for the seven-segment display path.

## Interface
Parameters:
- TIMEOUT_CYC, 1000000: cycles a pending prefix (E0/F0) may wait for its key byte before being discarded.
- CNT_W, 8: width of the press counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clrn  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from PS/2 receiver, valid while rx_ready=1.
- rx_ready  in  1  receiver has at least one byte available.
- rx_overflow  in  1  receiver FIFO overflow indication, level.
- nextdata_n  out  1  active-low pop strobe to receiver, one cycle per consumed byte.
- scan_out  out  8  scan code to lookup (combinational from held key; 0x00 when no key held).
- ascii_in  in  8  lookup result for scan_out (combinational).
- key_valid  out  1  a key is currently held.
- key_scan  out  8  scan code of held key.
- key_ext  out  1  held key was E0-prefixed.
- key_ascii  out  8  registered ASCII of held key; 0x00 if none or extended.
- press_cnt  out  CNT_W  number of distinct presses, wraps modulo 2^CNT_W.
- err  out  1  sticky error: overflow or prefix timeout.
- err_clr  in  1  synchronous clear of err.

## Operation
- Reset values: nextdata_n=1, key_valid=0, key_scan=0x00, key_ext=0, key_ascii=0x00, press_cnt=0, err=0, state=IDLE, prefixes cleared, timeout counter=0.
- States: IDLE, POP, DECODE.
  - IDLE: if rx_ready=1, capture rx_data into byte register and go to POP.
  - POP: nextdata_n=0 for this cycle only; rx_ready ignored; go to DECODE.
  - DECODE: classify the captured byte and return to IDLE.
- Classification in DECODE:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte is a key code.
- Key code with brk_pend=1 (release):
  - If key_valid and code==key_scan and ext_pend==key_ext, then key_valid←0 and key_scan←0x00.
  - Otherwise the held key is unchanged.
  - Clear both prefixes in either case.
- Key code with brk_pend=0 (make):
  - If key_valid and code==key_scan and ext_pend==key_ext, treat as typematic repeat: no state change, no count.
  - Otherwise key_scan←code, key_ext←ext_pend, key_valid←1, press_cnt←press_cnt+1.
  - Clear prefixes.
- key_ascii is registered every cycle as (key_valid & ~key_ext) ? ascii_in : 0x00.
- Timeout:
  - The counter runs while ext_pend|brk_pend=1 and resets to 0 whenever a byte is decoded.
  - On reaching TIMEOUT_CYC-1, clear both prefixes and set err.
  - The held key is unaffected.
- err is set by rx_overflow=1 in any cycle or by a timeout, and cleared by err_clr=1.
  - Set wins over clear in the same cycle.

## Timing
- Byte latency: rx_ready seen in cycle N (IDLE); nextdata_n low in N+1; key_* and press_cnt updated at the end of N+2, visible in N+3.
- key_ascii follows key_scan one cycle later (visible N+4).
- Throughput: at most one byte per 3 cycles.
  - Back-to-back bytes: IDLE re-samples rx_ready in N+3.
- nextdata_n is never low for two consecutive cycles.
- press_cnt wraps 2^CNT_W-1 → 0 without flagging.
- Reset asserted mid-sequence (in POP or DECODE) immediately returns all outputs to reset values, including nextdata_n=1.
  - The byte in flight is lost.

## Test plan
- Bytes 0x1C, then 0xF0,0x1C → key_valid=1, key_scan=0x1C, key_ascii=0x41, press_cnt=1; after the release key_valid=0, key_ascii=0x00.
- Typematic 0x1C,0x1C,0x1C, then 0xF0,0x1C → press_cnt=1; exactly 5 single-cycle nextdata_n pulses, each 3 cycles apart.
- Extended 0xE0,0x75, then 0xE0,0xF0,0x75 → key_ext=1, key_ascii=0x00, press_cnt=1; release clears key_valid. A plain 0xF0,0x75 does not clear it.
- Prefix 0xF0 then idle TIMEOUT_CYC cycles (parameter set to 16) → err=1, prefix dropped; the next 0x16 is a make with key_ascii=0x31.
- Press cnt set to 255 via 255 distinct press/release pairs, then one more press → press_cnt=0. rx_overflow pulse with simultaneous err_clr → err=1.
- clrn low during the POP cycle of byte 0x45 → all outputs at reset values, nextdata_n=1. After release, the next 0x45 gives key_ascii=0x30.
